seq_detect_prog: RTL and testbench

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/seq_match_window.sv | 73 +++++++
 rtl/seq_detect_prog.sv | 94 +++++++++
 tb/tb_seq_detect_prog.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared constants and helpers for the programmable serial sequence detector.
//   - DEF_RST_PATTERN / DEF_RST_LEN / DEF_RST_OVERLAP: power-on configuration
//     (pattern 1011, overlapping matches).
//   - len_width(): width needed to hold a pattern length 0..max_len.
package seq_detect_pkg;

  localparam logic [7:0] DEF_RST_PATTERN = 8'b0000_1011;
  localparam int         DEF_RST_LEN     = 4;
  localparam bit         DEF_RST_OVERLAP = 1'b1;

  // One extra bit over $clog2 so that max_len itself (a power of two) fits.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_match_window.sv
// seq_match_window
//   History shift register, fill counter and pattern comparator.
//   Ports:
//     clk, reset_n     : clock, synchronous active-low reset
//     clear            : wipe history and fill (accepted configuration load)
//     shift            : accept inp_bit this cycle
//     inp_bit          : serial data bit
//     pattern, len     : active pattern (right-aligned) and its length
//     overlap          : 1 = keep fill after a match, 0 = restart after a match
//     match            : combinational; high when the bit being accepted
//                        completes the pattern
module seq_match_window
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               shift,
  input  logic               inp_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-1:0] history_reg, history_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               enough;

  // Window as it would look with inp_bit already shifted in.
  assign cand = {history_reg[MAX_LEN-2:0], inp_bit};

  // Only the low len bits take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len);
    end
  endgenerate

  assign enough = ({1'b0, fill_reg} + (LEN_W+1)'(1)) >= {1'b0, len};
  assign match  = shift && enough && (((cand ^ pattern) & mask) == '0);

  always_comb begin
    history_next = history_reg;
    fill_next    = fill_reg;
    if (clear) begin
      history_next = '0;
      fill_next    = '0;
    end else if (shift) begin
      history_next = cand;
      if (match && !overlap)
        fill_next = '0;
      else if (fill_reg != LEN_W'(MAX_LEN))
        fill_next = fill_reg + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      history_reg <= '0;
      fill_reg    <= '0;
    end else begin
      history_reg <= history_next;
      fill_reg    <= fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
//   Programmable serial sequence detector with saturating match counter.
//   Ports:
//     clk, reset_n              : clock, synchronous active-low reset
//     inp_valid, inp_bit        : serial input, bit sampled when inp_valid=1
//     cfg_load                  : one-cycle request to load a configuration
//     cfg_pattern/len/overlap   : new configuration (pattern right-aligned,
//                                 bit [cfg_len-1] received first)
//     seq_seen                  : registered one-cycle match pulse
//     match_count               : saturating match count
//     cfg_err                   : sticky, set by a rejected configuration
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter  int                 MAX_LEN     = 8,
  parameter  int                 CNT_W       = 8,
  parameter  logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter  int                 RST_LEN     = DEF_RST_LEN,
  parameter  bit                 RST_OVERLAP = DEF_RST_OVERLAP,
  localparam int                 LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inp_valid,
  input  logic               inp_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic               seq_seen_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               cfg_err_reg;

  logic cfg_ok;
  logic shift;
  logic match;

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  // A configuration load in the same cycle swallows the input bit.
  assign shift  = inp_valid && !cfg_load;

  seq_match_window #(
    .MAX_LEN (MAX_LEN)
  ) u_win (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cfg_load && cfg_ok),
    .shift   (shift),
    .inp_bit (inp_bit),
    .pattern (pattern_reg),
    .len     (len_reg),
    .overlap (overlap_reg),
    .match   (match)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pattern_reg  <= RST_PATTERN;
      len_reg      <= LEN_W'(RST_LEN);
      overlap_reg  <= RST_OVERLAP;
      seq_seen_reg <= 1'b0;
      count_reg    <= '0;
      cfg_err_reg  <= 1'b0;
    end else begin
      seq_seen_reg <= match;
      if (cfg_load) begin
        if (cfg_ok) begin
          pattern_reg <= cfg_pattern;
          len_reg     <= cfg_len;
          overlap_reg <= cfg_overlap;
          count_reg   <= '0;
          cfg_err_reg <= 1'b0;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end else if (match && (count_reg != '1)) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign seq_seen    = seq_seen_reg;
  assign match_count = count_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog
//   Directed bench for seq_detect_prog. A bit-queue model of the detector
//   predicts seq_seen / match_count / cfg_err; a compare process checks both
//   instances (CNT_W=8 and CNT_W=2) every cycle, and literal checks pin the
//   headline scenarios.
module tb_seq_detect_prog;

  logic       clk         = 1'b0;
  logic       reset_n     = 1'b0;
  logic       inp_valid   = 1'b0;
  logic       inp_bit     = 1'b0;
  logic       cfg_load    = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len     = 4'd0;
  logic       cfg_overlap = 1'b0;

  logic       seq_seen, seq_seen2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic       cfg_err, cfg_err2;

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .reset_n(reset_n), .inp_valid(inp_valid), .inp_bit(inp_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .seq_seen(seq_seen), .match_count(match_count),
    .cfg_err(cfg_err)
  );

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .inp_valid(inp_valid), .inp_bit(inp_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .seq_seen(seq_seen2), .match_count(match_count2),
    .cfg_err(cfg_err2)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Model state: bits received since the last restart point.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ov;
  bit         m_seen;
  int         m_cnt, m_cnt2;
  bit         m_err;
  bit         m_live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_update();
    bit hit;
    m_seen = 1'b0;
    if (!reset_n) begin
      m_pat = 8'b0000_1011; m_len = 4; m_ov = 1'b1;
      q.delete(); m_cnt = 0; m_cnt2 = 0; m_err = 1'b0;
      m_live = 1'b1;
    end else if (cfg_load) begin
      if (cfg_len >= 1 && cfg_len <= 8) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap;
        q.delete(); m_cnt = 0; m_cnt2 = 0; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (inp_valid) begin
      q.push_back(inp_bit);
      if (q.size() > 8) void'(q.pop_front());
      hit = (q.size() >= m_len);
      if (hit)
        for (int k = 0; k < m_len; k++)
          if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
      m_seen = hit;
      if (hit) begin
        if (m_cnt  < 255) m_cnt++;
        if (m_cnt2 < 3)   m_cnt2++;
        if (!m_ov) q.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("seq_seen",     32'(seq_seen),     32'(m_seen));
      chk("match_count",  32'(match_count),  32'(m_cnt));
      chk("cfg_err",      32'(cfg_err),      32'(m_err));
      chk("seq_seen2",    32'(seq_seen2),    32'(m_seen));
      chk("match_count2", 32'(match_count2), 32'(m_cnt2));
    end
  end

  task automatic step(input bit rn, input bit v, input bit b, input bit ld,
                      input logic [7:0] pat, input logic [3:0] len, input bit ov);
    reset_n = rn; inp_valid = v; inp_bit = b; cfg_load = ld;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    @(posedge clk);
    model_update();
    #1;
    if (seq_seen) pulses++;
  endtask

  task automatic rst();                 step(0, 0, 0, 0, 8'h00, 4'd0, 0); endtask
  task automatic idle();                step(1, 0, 0, 0, 8'h00, 4'd0, 0); endtask
  task automatic sbit(input bit b);     step(1, 1, b, 0, 8'h00, 4'd0, 0); endtask
  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit ov);
    step(1, 0, 0, 1, p, l, ov);
  endtask
  task automatic bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sbit(v[i]);
  endtask

  initial begin
    // Reset state
    rst(); rst();
    chk("rst_seq_seen", 32'(seq_seen), 0);
    chk("rst_count",    32'(match_count), 0);
    chk("rst_cfg_err",  32'(cfg_err), 0);

    // Default pattern 1011 after reset
    pulses = 0;
    bits(16'b1011, 4);
    chk("pulse_after_4th", 32'(seq_seen), 1);
    idle();
    chk("def_pulses", 32'(pulses), 1);
    chk("def_count",  32'(match_count), 1);
    chk("model_def_count", 32'(m_cnt), 1);

    // Overlap vs non-overlap on 1011011
    load(8'h0B, 4'd4, 1'b1);
    pulses = 0;
    bits(16'b1011011, 7); idle();
    chk("ov1_pulses", 32'(pulses), 2);
    chk("ov1_count",  32'(match_count), 2);
    chk("model_ov1_count", 32'(m_cnt), 2);
    load(8'h0B, 4'd4, 1'b0);
    pulses = 0;
    bits(16'b1011011, 7); idle();
    chk("ov0_pulses", 32'(pulses), 1);
    chk("ov0_count",  32'(match_count), 1);

    // Full-width pattern A5 with gaps in inp_valid
    load(8'hA5, 4'd8, 1'b1);
    pulses = 0;
    for (int i = 15; i >= 0; i--) begin
      sbit(1'b0); // sixteen zeros must not match A5
    end
    chk("a5_no_false", 32'(pulses), 0);
    load(8'hA5, 4'd8, 1'b1);
    pulses = 0;
    begin
      logic [15:0] a5 = 16'hA5A5;
      for (int i = 15; i >= 0; i--) begin
        sbit(a5[i]);
        if (i % 3 == 0) idle();
      end
    end
    idle();
    chk("a5_pulses", 32'(pulses), 2);
    chk("a5_count",  32'(match_count), 2);

    // Rejected configurations keep the old one
    rst();
    load(8'h00, 4'd0, 1'b0);
    chk("len0_err", 32'(cfg_err), 1);
    pulses = 0;
    bits(16'b1011, 4); idle();
    chk("len0_still_detects", 32'(pulses), 1);
    load(8'h00, 4'd9, 1'b1);
    chk("len9_err",   32'(cfg_err), 1);
    chk("len9_count", 32'(match_count), 1);
    load(8'hFB, 4'd4, 1'b1);
    chk("valid_load_clears_err", 32'(cfg_err), 0);
    pulses = 0;
    bits(16'b1011, 4); idle();
    chk("upper_bits_ignored", 32'(pulses), 1);

    // Saturation of the 2-bit counter, and reset abandoning a sequence
    rst();
    pulses = 0;
    bits(16'b1011011011011011, 16); idle();
    chk("five_pulses",  32'(pulses), 5);
    chk("count8_five",  32'(match_count), 5);
    chk("count2_sat",   32'(match_count2), 3);
    pulses = 0;
    bits(16'b101, 3);
    rst();
    sbit(1'b1); idle();
    chk("rst_abandons", 32'(pulses), 0);
    chk("rst_abandons_count", 32'(match_count), 0);

    // cfg_load wins over inp_valid: bit dropped, history cleared
    rst();
    pulses = 0;
    bits(16'b101, 3);
    step(1, 1, 1, 1, 8'h0B, 4'd4, 1'b1);
    bits(16'b011, 3); idle();
    chk("load_drops_bit", 32'(pulses), 0);
    bits(16'b1011, 4); idle();
    chk("after_load_detect", 32'(pulses), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
